// File: rtl/display_scan_if.sv
// display_scan_if: digit data in, demux select/enable and segment data out
// for the multiplexed 7-segment scan controller.
interface display_scan_if;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        lz_blank;
    logic [1:0]  cont;
    logic        W;
    logic [3:0]  bcd;
    logic        dp;
    logic        frame_done;
    modport master(output en, digits, dp_mask, lz_blank,
                   input cont, W, bcd, dp, frame_done);
    modport slave(input en, digits, dp_mask, lz_blank,
                  output cont, W, bcd, dp, frame_done);
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit display scanner with blanking dead time,
// per-frame snapshot of digit data and optional leading-zero suppression.
module display_scan_ctrl #(
    parameter int SCAN_DIV     = 25000,
    parameter int BLANK_CYCLES = 250
) (
    input logic             clk,
    input logic             rst_n,
    display_scan_if.slave   s
);
    localparam int CW = $clog2(SCAN_DIV + 1);
    localparam logic [CW-1:0] BLK = CW'(BLANK_CYCLES);
    localparam logic [CW-1:0] DIV = CW'(SCAN_DIV);
    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   snap_d;
    logic [3:0]    snap_dp;
    logic          snap_lz;
    logic [3:0]    sup;
    logic [1:0]    nxt;
    always_comb begin
        sup[0] = 1'b0;
        sup[3] = snap_lz && snap_d[15:12] == 4'h0;
        sup[2] = sup[3] && snap_d[11:8] == 4'h0;
        sup[1] = sup[2] && snap_d[7:4] == 4'h0;
        nxt    = s.cont + 2'd1;
    end
    // cnt restarts at 1 for steady-state slots; entry from IDLE starts at 0,
    // giving the first slot one extra blank cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            snap_d       <= '0;
            snap_dp      <= '0;
            snap_lz      <= 1'b0;
            s.cont       <= '0;
            s.W          <= 1'b0;
            s.bcd        <= '0;
            s.dp         <= 1'b0;
            s.frame_done <= 1'b0;
        end else begin
            s.frame_done <= 1'b0;
            if (state != IDLE && !s.en) begin
                state  <= IDLE;
                cnt    <= '0;
                s.cont <= '0;
                s.W    <= 1'b0;
                s.bcd  <= snap_d[3:0];
                s.dp   <= snap_dp[0];
            end else begin
                case (state)
                    IDLE: if (s.en) begin
                        state   <= BLANK;
                        cnt     <= '0;
                        snap_d  <= s.digits;
                        snap_dp <= s.dp_mask;
                        snap_lz <= s.lz_blank;
                        s.bcd   <= s.digits[3:0];
                        s.dp    <= s.dp_mask[0];
                    end
                    BLANK: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == BLK) begin
                            state <= ON;
                            s.W   <= ~sup[s.cont];
                        end
                    end
                    ON: if (cnt == DIV) begin
                        state  <= BLANK;
                        cnt    <= CW'(1);
                        s.W    <= 1'b0;
                        s.cont <= nxt;
                        if (s.cont == 2'd3) begin
                            s.frame_done <= 1'b1;
                            snap_d       <= s.digits;
                            snap_dp      <= s.dp_mask;
                            snap_lz      <= s.lz_blank;
                            s.bcd        <= s.digits[3:0];
                            s.dp         <= s.dp_mask[0];
                        end else begin
                            s.bcd <= snap_d[{nxt, 2'b00} +: 4];
                            s.dp  <= snap_dp[nxt];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed scan scenarios; a monitor scores each completed
// digit slot (cont, bcd, dp, lit cycles) against a queue of expected slots.
module tb_display_scan_ctrl;
    localparam int S = 8;
    localparam int B = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    display_scan_if bus();
    display_scan_ctrl #(.SCAN_DIV(S), .BLANK_CYCLES(B)) dut (.clk(clk), .rst_n(rst_n), .s(bus));
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] cont;
        logic [3:0] bcd;
        logic       dp;
        logic [7:0] on;
    } slot_t;
    slot_t q[$];
    slot_t e;
    int n_cmp = 0;
    int n_fail = 0;
    int fd_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // monitor: a change of cont closes the previous slot's record
    logic [1:0] pc;
    logic [3:0] pb;
    logic       pd;
    int         on;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc = '0; pb = '0; pd = 1'b0; on = 0;
        end else begin
            if (bus.frame_done) fd_cnt++;
            if (bus.cont != pc) begin
                chk("W low at digit change", int'(bus.W), 0);
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected slot: got cont %0d, expected none", pc);
                end else begin
                    e = q.pop_front();
                    chk("slot cont", int'(pc), int'(e.cont));
                    chk("slot bcd", int'(pb), int'(e.bcd));
                    chk("slot dp", int'(pd), int'(e.dp));
                    chk("slot lit cycles", on, int'(e.on));
                end
                on = 0;
            end
            if (bus.W) on++;
            pc = bus.cont; pb = bus.bcd; pd = bus.dp;
        end
    end

    task automatic push_frame(input logic [15:0] d, input logic [3:0] m, input logic [3:0] lit);
        for (int i = 0; i < 4; i++)
            q.push_back({2'(i), d[i*4 +: 4], m[i], lit[i] ? 8'(S - B) : 8'd0});
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 * S && !ok; i++) begin
            @(negedge clk);
            ok = bus.frame_done;
        end
    endtask

    task automatic start(input logic [15:0] d, input logic [3:0] m, input logic lz);
        int n;
        bus.digits = d; bus.dp_mask = m; bus.lz_blank = lz; bus.en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.W && n < 50);
        chk("enable latency", n, B + 2);
        chk("cont at first W", int'(bus.cont), 0);
    endtask

    task automatic run_frame(input logic [15:0] d, input logic [3:0] m, input logic lz, input logic [3:0] lit);
        bit ok;
        push_frame(d, m, lit);
        start(d, m, lz);
        wait_fd(ok);
        chk("frame_done seen", int'(ok), 1);
        chk("cont at frame_done", int'(bus.cont), 0);
        bus.en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int w, fd0;
        time t1;
        bus.en = 1'b0; bus.digits = 16'h4321; bus.dp_mask = 4'hF; bus.lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset cont", int'(bus.cont), 0);
        chk("reset W", int'(bus.W), 0);
        chk("reset bcd", int'(bus.bcd), 0);
        chk("reset dp", int'(bus.dp), 0);
        chk("reset frame_done", int'(bus.frame_done), 0);
        rst_n = 1'b1;
        fd0 = fd_cnt; w = 0;
        repeat (100) begin
            @(negedge clk);
            w += int'(bus.W);
        end
        chk("idle W cycles", w, 0);
        chk("idle frame_done", fd_cnt, fd0);
        chk("idle cont", int'(bus.cont), 0);
        chk("idle bcd", int'(bus.bcd), 0);

        // basic scan, then tear-free update of digits while cont=1
        bus.dp_mask = 4'h0;
        push_frame(16'h4321, 4'h0, 4'hF);
        push_frame(16'h8765, 4'h0, 4'hF);
        start(16'h4321, 4'h0, 1'b0);
        for (int i = 0; i < 4 * S && bus.cont != 2'd1; i++) @(negedge clk);
        chk("reached cont 1", int'(bus.cont), 1);
        bus.digits = 16'h8765;
        wait_fd(ok);
        chk("first frame_done", int'(ok), 1);
        t1 = $time;
        wait_fd(ok);
        chk("second frame_done", int'(ok), 1);
        chk("frame period", int'(($time - t1) / 10), 4 * S);
        bus.en = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(16'h0020, 4'h0, 1'b1, 4'b0011);
        run_frame(16'h0000, 4'h0, 1'b1, 4'b0001);
        run_frame(16'h4321, 4'b0100, 1'b0, 4'b1111);
        run_frame(16'h0000, 4'b0100, 1'b1, 4'b0001);
        run_frame(16'h0B0A, 4'h0, 1'b1, 4'b0111);

        // enable dropped in the ON phase of digit 2
        q.push_back({2'd0, 4'd1, 1'b0, 8'(S - B)});
        q.push_back({2'd1, 4'd2, 1'b0, 8'(S - B)});
        q.push_back({2'd2, 4'd3, 1'b0, 8'd1});
        start(16'h4321, 4'h0, 1'b0);
        for (int i = 0; i < 4 * S && !(bus.cont == 2'd2 && bus.W); i++) @(negedge clk);
        chk("reached cont 2 on", int'(bus.cont == 2'd2 && bus.W), 1);
        fd0 = fd_cnt;
        bus.en = 1'b0;
        @(negedge clk);
        chk("drop W", int'(bus.W), 0);
        chk("drop cont", int'(bus.cont), 0);
        chk("drop bcd", int'(bus.bcd), 1);
        repeat (5) @(negedge clk);
        chk("drop frame_done", fd_cnt, fd0);
        run_frame(16'h4321, 4'h0, 1'b0, 4'hF);

        // asynchronous reset between clock edges
        q.push_back({2'd0, 4'd1, 1'b0, 8'(S - B)});
        start(16'h4321, 4'b0010, 1'b0);
        for (int i = 0; i < 4 * S && !(bus.cont == 2'd1 && bus.W); i++) @(negedge clk);
        chk("reached cont 1 on", int'(bus.cont == 2'd1 && bus.W), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async cont", int'(bus.cont), 0);
        chk("async W", int'(bus.W), 0);
        chk("async bcd", int'(bus.bcd), 0);
        chk("async dp", int'(bus.dp), 0);
        bus.en = 1'b0;
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(16'h9876, 4'h0, 1'b0, 4'hF);

        repeat (2) @(negedge clk);
        chk("queue drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
